chip8_mem_arbiter: RTL and testbench

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

---
 rtl/chip8_mem_arbiter_pkg.sv | 30 +++
 rtl/chip8_mem_arbiter_pipe.sv | 26 ++
 rtl/chip8_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared definitions for the CHIP-8 memory arbiter: requester ids, FSM states,
// read-return tags and the round-robin index helper.
package chip8_mem_arbiter_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_PROC  = 2'd0;
  localparam logic [1:0] REQ_VIDEO = 2'd1;
  localparam logic [1:0] REQ_DEBUG = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [1:0] id;
    logic       first;
    logic       last;
  } rd_tag_t;

  // (base + off) mod NUM_REQ for base, off in 0..2
  function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

endpackage

// File: rtl/chip8_mem_arbiter_pipe.sv
// Fixed-depth delay line; the arbiter uses it to carry read tags alongside
// the memory's read latency.
module chip8_mem_arbiter_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 4
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);
  logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) stage_q <= '0;
    else           stage_q <= stage_d;
  end

  assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Three-way round-robin arbiter onto a byte-wide shared memory port; words are
// split into two big-endian beats and read data is reassembled from tags.
module chip8_mem_arbiter
  import chip8_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [2:0]          req_valid_in,
  output logic [2:0]          req_ready_out,
  input  logic [3*ADDR_W-1:0] req_addr_in,
  input  logic [2:0]          req_we_in,
  input  logic [2:0]          req_size_in,
  input  logic [3*16-1:0]     req_wdata_in,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic                mem_we_out,
  output logic [7:0]          mem_wdata_out,
  input  logic [7:0]          mem_rdata_in,
  output logic [2:0]          rsp_valid_out,
  output logic [15:0]         rsp_data_out
);
  arb_state_e        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d, id_q, id_d;
  logic              we_q, we_d, size_q, size_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        hi_q, hi_d;
  logic              hi_vld_q, hi_vld_d;

  logic [ADDR_W-1:0] r_addr  [NUM_REQ];
  logic [15:0]       r_wdata [NUM_REQ];
  logic [1:0]        win;
  logic              win_vld;
  logic [2:0]        grant;
  rd_tag_t           tag_in, tag_out;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign r_addr[i]  = req_addr_in[i*ADDR_W +: ADDR_W];
    assign r_wdata[i] = req_wdata_in[i*16 +: 16];
  end

  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req_valid_in[rr_step(ptr_q, 2'(k))]) begin
        win     = rr_step(ptr_q, 2'(k));
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    we_d        = we_q;
    size_d      = size_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    grant       = '0;
    tag_in      = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant[win]  = 1'b1;
          ptr_d       = rr_step(win, 2'd1);
          id_d        = win;
          we_d        = req_we_in[win];
          size_d      = req_size_in[win];
          lo_d        = r_wdata[win][7:0];
          mem_addr_d  = r_addr[win];
          mem_we_d    = req_we_in[win];
          mem_wdata_d = req_size_in[win] ? r_wdata[win][15:8] : r_wdata[win][7:0];
          state_d     = BEAT0;
        end
      end
      BEAT0: begin
        if (!we_q) begin
          tag_in.id    = id_q;
          tag_in.first = size_q;
          tag_in.last  = !size_q;
        end
        if (size_q) begin
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_we_d    = we_q;
          mem_wdata_d = lo_q;
          state_d     = BEAT1;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT1: begin
        if (!we_q) begin
          tag_in.id   = id_q;
          tag_in.last = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_out = grant & {NUM_REQ{rst_n_in}};

  chip8_mem_arbiter_pipe #(
    .DEPTH (READ_LATENCY),
    .W     ($bits(rd_tag_t))
  ) u_tag_pipe (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d_in     (tag_in),
    .q_out    (tag_out)
  );

  // Word beats return on consecutive cycles, so a last tag that directly
  // follows a first tag completes a word; any other last tag is a byte.
  always_comb begin
    hi_d          = tag_out.first ? mem_rdata_in : hi_q;
    hi_vld_d      = tag_out.first;
    rsp_valid_out = '0;
    rsp_data_out  = '0;
    if (tag_out.last) begin
      rsp_valid_out[tag_out.id] = 1'b1;
      rsp_data_out              = {hi_vld_q ? hi_q : 8'h00, mem_rdata_in};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_PROC;
      id_q        <= '0;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      lo_q        <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      hi_q        <= '0;
      hi_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      hi_q        <= hi_d;
      hi_vld_q    <= hi_vld_d;
    end
  end

  assign mem_addr_out  = mem_addr_q;
  assign mem_we_out    = mem_we_q;
  assign mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a byte memory model that returns
// read data three cycles after the address is presented.
module tb_chip8_mem_arbiter;
  localparam int AW = 13;
  localparam int RL = 3;

  logic          clk_in, rst_n_in;
  logic [2:0]    req_valid_in, req_ready_out, req_we_in, req_size_in;
  logic [3*AW-1:0] req_addr_in;
  logic [47:0]   req_wdata_in;
  logic [AW-1:0] mem_addr_out;
  logic          mem_we_out;
  logic [7:0]    mem_wdata_out, mem_rdata_in;
  logic [2:0]    rsp_valid_out;
  logic [15:0]   rsp_data_out;

  int checks = 0;
  int failures = 0;
  logic [2:0] seen;

  chip8_mem_arbiter #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_addr_in   (req_addr_in),
    .req_we_in     (req_we_in),
    .req_size_in   (req_size_in),
    .req_wdata_in  (req_wdata_in),
    .mem_addr_out  (mem_addr_out),
    .mem_we_out    (mem_we_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // memory model: preload while in reset, write on strobe, delayed read
  logic [7:0]    mem [8192];
  logic [AW-1:0] rd_a [RL];
  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      mem[13'h0200] <= 8'hA2;
      mem[13'h1FFF] <= 8'h12;
      mem[13'h0000] <= 8'h34;
      mem[13'h0400] <= 8'h56;
      mem[13'h0401] <= 8'h78;
      mem[13'h0500] <= 8'h9A;
    end else if (mem_we_out) begin
      mem[mem_addr_out] <= mem_wdata_out;
    end
    rd_a[0] <= mem_addr_out;
    for (int i = 1; i < RL; i++) rd_a[i] <= rd_a[i-1];
  end
  assign mem_rdata_in = mem[rd_a[RL-1]];

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic we,
                         input logic sz, input logic [15:0] wd);
    req_addr_in[r*AW +: AW]  = a;
    req_we_in[r]             = we;
    req_size_in[r]           = sz;
    req_wdata_in[r*16 +: 16] = wd;
  endtask

  initial begin
    rst_n_in = 1'b1; req_valid_in = '0; req_we_in = '0; req_size_in = '0;
    req_addr_in = '0; req_wdata_in = '0;
    #2 rst_n_in = 1'b0;
    #1 req_valid_in = 3'b111;
    #1;
    chk("rst_ready", req_ready_out, 3'b000);
    chk("rst_rsp_valid", rsp_valid_out, 3'b000);
    chk("rst_rsp_data", rsp_data_out, 16'h0000);
    chk("rst_mem_addr", mem_addr_out, 13'h0000);
    chk("rst_mem_we", mem_we_out, 1'b0);
    chk("rst_mem_wdata", mem_wdata_out, 8'h00);
    req_valid_in = '0;
    tick(); tick();
    rst_n_in = 1'b1;

    // proc byte read of 0x200
    tick();
    set_req(0, 13'h0200, 1'b0, 1'b0, 16'h0000);
    req_valid_in = 3'b001; #1;
    chk("br_ready", req_ready_out, 3'b001);
    tick(); req_valid_in = '0;
    chk("br_addr", mem_addr_out, 13'h0200);
    chk("br_we", mem_we_out, 1'b0);
    chk("br_ready_beat", req_ready_out, 3'b000);
    tick();
    chk("br_hold_addr", mem_addr_out, 13'h0200);
    chk("br_early1", rsp_valid_out, 3'b000);
    tick();
    chk("br_early2", rsp_valid_out, 3'b000);
    tick();
    chk("br_rsp_valid", rsp_valid_out, 3'b001);
    chk("br_rsp_data", rsp_data_out, 16'h00A2);
    tick();
    chk("br_rsp_pulse", rsp_valid_out, 3'b000);

    // video word write 0xBEEF to 0x1005
    set_req(1, 13'h1005, 1'b1, 1'b1, 16'hBEEF);
    req_valid_in = 3'b010; #1;
    chk("ww_ready", req_ready_out, 3'b010);
    tick(); req_valid_in = '0;
    chk("ww_b0_addr", mem_addr_out, 13'h1005);
    chk("ww_b0_we", mem_we_out, 1'b1);
    chk("ww_b0_data", mem_wdata_out, 8'hBE);
    tick();
    chk("ww_b1_addr", mem_addr_out, 13'h1006);
    chk("ww_b1_we", mem_we_out, 1'b1);
    chk("ww_b1_data", mem_wdata_out, 8'hEF);
    tick();
    chk("ww_idle_we", mem_we_out, 1'b0);
    chk("ww_idle_addr", mem_addr_out, 13'h1006);
    chk("ww_idle_data", mem_wdata_out, 8'hEF);
    chk("ww_mem_hi", mem[13'h1005], 8'hBE);
    chk("ww_mem_lo", mem[13'h1006], 8'hEF);
    seen = rsp_valid_out;
    for (int i = 0; i < 4; i++) begin tick(); seen |= rsp_valid_out; end
    chk("ww_no_rsp", seen, 3'b000);

    // debug word read wrapping 0x1FFF -> 0x0000
    set_req(2, 13'h1FFF, 1'b0, 1'b1, 16'h0000);
    req_valid_in = 3'b100; #1;
    chk("wrap_ready", req_ready_out, 3'b100);
    tick(); req_valid_in = '0;
    chk("wrap_b0_addr", mem_addr_out, 13'h1FFF);
    tick();
    chk("wrap_b1_addr", mem_addr_out, 13'h0000);
    chk("wrap_b1_we", mem_we_out, 1'b0);
    tick(); tick();
    chk("wrap_first_no_rsp", rsp_valid_out, 3'b000);
    tick();
    chk("wrap_rsp_valid", rsp_valid_out, 3'b100);
    chk("wrap_rsp_data", rsp_data_out, 16'h1234);
    tick();

    // all three valid: fair rotation over nine byte-write grants
    set_req(0, 13'h0300, 1'b1, 1'b0, 16'h0010);
    set_req(1, 13'h0301, 1'b1, 1'b0, 16'h0011);
    set_req(2, 13'h0302, 1'b1, 1'b0, 16'h0012);
    req_valid_in = 3'b111; #1;
    for (int g = 0; g < 9; g++) begin
      chk($sformatf("rr_grant%0d", g), req_ready_out, 3'b001 << (g % 3));
      tick();
      chk($sformatf("rr_busy%0d", g), req_ready_out, 3'b000);
      if (g == 8) req_valid_in = '0;
      tick();
    end
    chk("rr_mem2", mem[13'h0302], 8'h12);

    // proc word read, then video byte read right behind it
    set_req(0, 13'h0400, 1'b0, 1'b1, 16'h0000);
    set_req(1, 13'h0500, 1'b0, 1'b0, 16'h0000);
    req_valid_in = 3'b011; #1;
    chk("b2b_grant_proc", req_ready_out, 3'b001);
    tick(); req_valid_in = 3'b010;
    tick();
    tick();
    chk("b2b_grant_video", req_ready_out, 3'b010);
    tick(); req_valid_in = '0;
    chk("b2b_quiet", rsp_valid_out, 3'b000);
    tick();
    chk("b2b_rsp0_valid", rsp_valid_out, 3'b001);
    chk("b2b_rsp0_data", rsp_data_out, 16'h5678);
    tick();
    chk("b2b_gap", rsp_valid_out, 3'b000);
    tick();
    chk("b2b_rsp1_valid", rsp_valid_out, 3'b010);
    chk("b2b_rsp1_data", rsp_data_out, 16'h009A);
    tick();

    // reset during BEAT1 of a proc word read
    set_req(0, 13'h0400, 1'b0, 1'b1, 16'h0000);
    req_valid_in = 3'b001; #1;
    chk("rb_grant", req_ready_out, 3'b001);
    tick(); req_valid_in = '0;
    tick();
    chk("rb_in_beat1", mem_addr_out, 13'h0401);
    rst_n_in = 1'b0; #1;
    chk("rb_addr0", mem_addr_out, 13'h0000);
    chk("rb_we0", mem_we_out, 1'b0);
    chk("rb_wdata0", mem_wdata_out, 8'h00);
    chk("rb_rsp0", rsp_valid_out, 3'b000);
    chk("rb_data0", rsp_data_out, 16'h0000);
    seen = '0;
    tick(); seen |= rsp_valid_out;
    rst_n_in = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); seen |= rsp_valid_out; end
    chk("rb_no_rsp", seen, 3'b000);
    set_req(0, 13'h0310, 1'b1, 1'b0, 16'h0001);
    set_req(1, 13'h0311, 1'b1, 1'b0, 16'h0002);
    set_req(2, 13'h0312, 1'b1, 1'b0, 16'h0003);
    req_valid_in = 3'b111; #1;
    chk("rb_next_grant", req_ready_out, 3'b001);
    tick(); req_valid_in = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
